// File: rtl/flit_activity_monitor.sv
// Groups adder-output flits into idle-delimited packets and reports
// per-packet flit count and bit-toggle activity over a valid/ready port.
module flit_activity_monitor #(
    parameter int N        = 12,
    parameter int FLIT_W   = 8,
    parameter int TOG_W    = 16,
    parameter int IDLE_GAP = 3,
    parameter int PKT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [N-1:0]      in_data,
    output logic              rep_valid,
    input  logic              rep_ready,
    output logic [FLIT_W-1:0] rep_flits,
    output logic [TOG_W-1:0]  rep_toggles,
    output logic              rep_overrun,
    output logic [PKT_W-1:0]  total_pkts
);

    localparam int GAP_W = $clog2(IDLE_GAP + 1);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(IDLE_GAP);
    localparam logic [FLIT_W-1:0] CNT_ONE  = FLIT_W'(1);
    localparam logic [PKT_W-1:0]  PKT_ONE  = PKT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d, gap_nxt;
    logic [FLIT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TOG_W-1:0]  tog_q, tog_d, tog_inc, tog_first;
    logic [N-1:0]      prev_q, prev_d;
    logic [TOG_W:0]    pc, tog_sum;
    logic              close, load, drop;

    function automatic logic [TOG_W:0] popcnt(input logic [N-1:0] d);
        logic [TOG_W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{TOG_W{1'b0}}, d[i]};
        end
        return c;
    endfunction

    // Saturating activity arithmetic for the flit being sampled
    always_comb begin
        pc        = popcnt(in_data ^ prev_q);
        tog_sum   = {1'b0, tog_q} + pc;
        tog_inc   = tog_sum[TOG_W] ? '1 : tog_sum[TOG_W-1:0];
        tog_first = pc[TOG_W] ? '1 : pc[TOG_W-1:0];
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
        gap_nxt   = gap_q + GAP_ONE;
    end

    // Packet framing: next state, counters and the closing strobe
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        tog_d   = tog_q;
        prev_d  = prev_q;
        close   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RECV;
                    cnt_d   = CNT_ONE;
                    tog_d   = tog_first;
                    prev_d  = in_data;
                    gap_d   = '0;
                end
            end
            RECV: begin
                if (in_valid) begin
                    cnt_d  = cnt_inc;
                    tog_d  = tog_inc;
                    prev_d = in_data;
                end else if (IDLE_GAP == 1) begin
                    close   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    tog_d   = '0;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_ONE;
                end
            end
            GAP: begin
                if (in_valid) begin
                    state_d = RECV;
                    gap_d   = '0;
                    cnt_d   = cnt_inc;
                    tog_d   = tog_inc;
                    prev_d  = in_data;
                end else if (gap_nxt == GAP_LAST) begin
                    close   = 1'b1;
                    state_d = IDLE;
                    gap_d   = '0;
                    cnt_d   = '0;
                    tog_d   = '0;
                end else begin
                    gap_d = gap_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Framing state and per-packet accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= '0;
            cnt_q   <= '0;
            tog_q   <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            tog_q   <= tog_d;
            prev_q  <= prev_d;
        end
    end

    assign load = close & (~rep_valid | rep_ready);
    assign drop = close & rep_valid & ~rep_ready;

    // Report register, handshake, overrun flag and packet counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_valid   <= 1'b0;
            rep_flits   <= '0;
            rep_toggles <= '0;
            rep_overrun <= 1'b0;
            total_pkts  <= '0;
        end else begin
            if (close) begin
                total_pkts <= total_pkts + PKT_ONE;
            end
            if (load) begin
                rep_valid   <= 1'b1;
                rep_flits   <= cnt_q;
                rep_toggles <= tog_q;
            end else if (rep_ready) begin
                rep_valid <= 1'b0;
            end
            if (drop) begin
                rep_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flit_activity_monitor.sv
// Directed and randomized checks of flit_activity_monitor against a
// packet-level activity model (popcount of consecutive flit XORs).
module tb_flit_activity_monitor;

    localparam int N        = 12;
    localparam int FLIT_W   = 8;
    localparam int TOG_W    = 16;
    localparam int IDLE_GAP = 3;
    localparam int PKT_W    = 16;

    typedef logic [N-1:0] flit_t;
    typedef struct {
        int flits;
        int tog;
        int at;
    } rep_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [N-1:0]      in_data = '0;
    logic              rep_ready = 1'b0;
    logic              rep_valid;
    logic [FLIT_W-1:0] rep_flits;
    logic [TOG_W-1:0]  rep_toggles;
    logic              rep_overrun;
    logic [PKT_W-1:0]  total_pkts;

    flit_activity_monitor #(
        .N(N), .FLIT_W(FLIT_W), .TOG_W(TOG_W),
        .IDLE_GAP(IDLE_GAP), .PKT_W(PKT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data),
        .rep_valid(rep_valid), .rep_ready(rep_ready),
        .rep_flits(rep_flits), .rep_toggles(rep_toggles),
        .rep_overrun(rep_overrun), .total_pkts(total_pkts)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    // Edge counter used to time reports against the last flit
    always @(posedge clk) cyc <= cyc + 1;

    rep_t repq[$];
    int   vcount = 0;
    // Report monitor, sampled mid-cycle
    always @(negedge clk) begin : mon
        rep_t r;
        if (rep_valid) vcount++;
        if (rep_valid && rep_ready) begin
            r.flits = int'(rep_flits);
            r.tog   = int'(rep_toggles);
            r.at    = cyc;
            repq.push_back(r);
        end
    end

    int    total = 0;
    int    bad = 0;
    flit_t prev_m = '0;
    int    pkts_m = 0;
    int    last_c = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input flit_t d);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, flit_t'($urandom));
    endtask

    task automatic send(input flit_t d[$]);
        foreach (d[i]) begin
            step(1'b1, d[i]);
            last_c = cyc;
        end
    endtask

    // Packet-level model: count and saturated sum of popcounts
    task automatic model_pkt(input flit_t d[$], output int f, output int t);
        longint s = 0;
        foreach (d[i]) begin
            s += $countones(d[i] ^ prev_m);
            prev_m = d[i];
        end
        f = (d.size() > 255) ? 255 : d.size();
        t = (s > 65535) ? 65535 : int'(s);
        pkts_m++;
    endtask

    task automatic get_rep(input string tag, output rep_t r);
        int n = 0;
        while (repq.size() == 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_present"}, repq.size() > 0, 1);
        if (repq.size() > 0) r = repq.pop_front();
        else begin
            r.flits = -1;
            r.tog   = -1;
            r.at    = -1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        prev_m = '0;
        pkts_m = 0;
        repq.delete();
    endtask

    function automatic void alt(ref flit_t q[$], input int n, input flit_t first);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back((i % 2 == 0) ? first : ~first);
    endfunction

    initial begin
        flit_t q[$];
        flit_t a[$];
        flit_t b[$];
        rep_t  r;
        int    f, t, f1, t1, v0;

        rep_ready = 1'b1;
        rst_n = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
            in_data  = flit_t'($urandom);
        end
        chk("rst_valid", rep_valid, 0);
        chk("rst_flits", rep_flits, 0);
        chk("rst_tog", rep_toggles, 0);
        chk("rst_ovr", rep_overrun, 0);
        chk("rst_pkts", total_pkts, 0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        idle(5);
        chk("post_rst_valid", rep_valid, 0);
        chk("post_rst_pkts", total_pkts, 0);
        chk("post_rst_noreport", repq.size(), 0);

        alt(q, 20, 12'hFFF);
        for (int p = 0; p < 10; p++) begin
            v0 = vcount;
            send(q);
            idle(7);
            model_pkt(q, f, t);
            get_rep("inj", r);
            chk("inj_flits", r.flits, f);
            chk("inj_tog", r.tog, t);
            if (p == 0) begin
                chk("inj_tog_240", r.tog, 240);
                chk("inj_latency", r.at, last_c + 1 + IDLE_GAP);
                chk("inj_1cycle", vcount - v0, 1);
            end
        end
        chk("inj_pkts", total_pkts, pkts_m);
        chk("inj_pkts10", total_pkts, 10);

        do_reset();
        q.delete();
        repeat (10) q.push_back(12'h555);
        send(q);
        idle(3);
        model_pkt(q, f, t);
        get_rep("const", r);
        chk("const_flits", r.flits, 10);
        chk("const_tog", r.tog, t);
        chk("const_tog6", r.tog, 6);

        do_reset();
        a.delete();
        b.delete();
        repeat (5) a.push_back(flit_t'($urandom));
        repeat (5) b.push_back(flit_t'($urandom));
        send(a);
        idle(2);
        send(b);
        idle(5);
        q = {a, b};
        model_pkt(q, f, t);
        get_rep("merge", r);
        chk("merge_flits", r.flits, 10);
        chk("merge_tog", r.tog, t);
        chk("merge_single", repq.size(), 0);
        chk("merge_pkts", total_pkts, 1);

        do_reset();
        rep_ready = 1'b0;
        a.delete();
        b.delete();
        repeat (4) a.push_back(flit_t'($urandom));
        repeat (6) b.push_back(flit_t'($urandom));
        send(a);
        idle(4);
        model_pkt(a, f1, t1);
        send(b);
        idle(5);
        model_pkt(b, f, t);
        chk("bp_valid", rep_valid, 1);
        chk("bp_flits", rep_flits, f1);
        chk("bp_tog", rep_toggles, t1);
        chk("bp_ovr", rep_overrun, 1);
        chk("bp_pkts", total_pkts, 2);
        rep_ready = 1'b1;
        step(1'b0, '0);
        chk("bp_drop_valid", rep_valid, 0);
        chk("bp_ovr_sticky", rep_overrun, 1);
        get_rep("bp", r);
        chk("bp_xfer_flits", r.flits, 4);

        do_reset();
        alt(q, 300, 12'hFFF);
        send(q);
        idle(4);
        model_pkt(q, f, t);
        get_rep("sat", r);
        chk("sat_flits", r.flits, 255);
        chk("sat_tog", r.tog, t);
        chk("sat_tog3600", r.tog, 3600);
        alt(q, 6000, 12'h000);
        send(q);
        idle(4);
        model_pkt(q, f, t);
        get_rep("tsat", r);
        chk("tsat_flits", r.flits, f);
        chk("tsat_tog", r.tog, 65535);

        for (int p = 0; p < 15; p++) begin
            q.delete();
            repeat ($urandom_range(1, 40)) q.push_back(flit_t'($urandom));
            send(q);
            idle($urandom_range(IDLE_GAP, IDLE_GAP + 4));
            model_pkt(q, f, t);
            get_rep("rnd", r);
            chk("rnd_flits", r.flits, f);
            chk("rnd_tog", r.tog, t);
        end
        chk("rnd_pkts", total_pkts, pkts_m);

        q.delete();
        repeat (5) q.push_back(flit_t'($urandom));
        send(q);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repq.delete();
        idle(6);
        chk("mid_rst_noreport", repq.size(), 0);
        chk("mid_rst_valid", rep_valid, 0);
        chk("mid_rst_pkts", total_pkts, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
